// File: rtl/quad_decoder_v2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : quad_decoder_v2                                                 |
// | Purpose  : Quadrature encoder decoder. Synchronises and glitch-filters the |
// |            A/B/I pins, decodes x1/x2/x4 steps into a wrapping position     |
// |            counter and measures a windowed signed step count (velocity).   |
// | Ports    : clk, rst            - clock, synchronous active-high reset      |
// |            quad_a/b/i          - asynchronous encoder pins                 |
// |            mode                - 00/11 x4, 01 x2, 10 x1                    |
// |            index_clr_en        - allow index rising edge to clear count    |
// |            preset, preset_val  - one-cycle load of the position counter    |
// |            err_clr             - one-cycle clear of the sticky error flag  |
// |            count_o, dir_o      - position and direction of last step       |
// |            err_o               - sticky illegal-transition flag            |
// |            vel_o, vel_valid_o  - net steps of last window, update strobe   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module quad_decoder_v2 #(
  parameter int                 CNT_W      = 32,
  parameter int                 FILT_LEN   = 4,
  parameter int                 VEL_PERIOD = 100000,
  parameter logic [CNT_W-1:0]   CNT_INIT   = {1'b0, {(CNT_W-1){1'b1}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             quad_i,
  input  logic [1:0]       mode,
  input  logic             index_clr_en,
  input  logic             preset,
  input  logic [CNT_W-1:0] preset_val,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count_o,
  output logic             dir_o,
  output logic             err_o,
  output logic [CNT_W-1:0] vel_o,
  output logic             vel_valid_o
);

  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(VEL_PERIOD - 1);
  localparam logic [8:0]       FILT_HELD = 9'(FILT_LEN);
  localparam logic [7:0]       FILT_SAT  = 8'(FILT_LEN);

  // Pin vector ordering: bit 2 = A, bit 1 = B, bit 0 = I.
  logic [2:0]       pins;
  logic [2:0]       sync1, sync2;
  logic [2:0]       cand;            // previous synchronised value
  logic [7:0]       cnt [3];         // consecutive cycles cand has been held
  logic [2:0]       filt;
  logic [2:0]       qualified;       // filter has accepted at least one level
  logic [8:0]       held [3];
  logic [2:0]       accept;

  logic             init_done;
  logic [1:0]       prev_ab;
  logic             prev_i;
  logic             i_qual_d;

  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_step;

  logic [1:0]       new_ab;
  logic [1:0]       nxt_fwd, nxt_rev;
  logic             illegal, is_fwd, is_rev, a_edge, a_rise, mode_ok;
  logic             step_fwd, step_rev, idx_rise;

  assign pins = {quad_a, quad_b, quad_i};

  // Held count includes the current cycle; the counter saturates at FILT_LEN
  // so a long-stable level keeps being accepted without overflow.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      held[k]   = (sync2[k] == cand[k]) ? ({1'b0, cnt[k]} + 9'd1) : 9'd1;
      accept[k] = (held[k] >= FILT_HELD);
    end
  end

  // Forward order 00->10->11->01: next_fwd({a,b}) = {~b,a}, next_rev = {b,~a}.
  always_comb begin
    new_ab   = filt[2:1];
    nxt_fwd  = {~prev_ab[0], prev_ab[1]};
    nxt_rev  = {prev_ab[0], ~prev_ab[1]};
    illegal  = init_done && (new_ab == ~prev_ab);
    is_fwd   = init_done && (new_ab == nxt_fwd);
    is_rev   = init_done && (new_ab == nxt_rev);
    a_edge   = new_ab[1] ^ prev_ab[1];
    a_rise   = new_ab[1] & ~prev_ab[1];
    case (mode)
      2'b01:   mode_ok = a_edge;
      2'b10:   mode_ok = a_rise;
      default: mode_ok = 1'b1;
    endcase
    step_fwd = is_fwd & mode_ok;
    step_rev = is_rev & mode_ok;
    idx_rise = filt[0] & ~prev_i & i_qual_d;
    acc_step = acc;
    if (step_fwd)      acc_step = acc + ONE;
    else if (step_rev) acc_step = acc - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      cand        <= '0;
      filt        <= '0;
      qualified   <= '0;
      for (int k = 0; k < 3; k++) cnt[k] <= '0;
      init_done   <= 1'b0;
      prev_ab     <= '0;
      prev_i      <= 1'b0;
      i_qual_d    <= 1'b0;
      count_o     <= CNT_INIT;
      dir_o       <= 1'b0;
      err_o       <= 1'b0;
      vel_o       <= '0;
      vel_valid_o <= 1'b0;
      win_cnt     <= '0;
      acc         <= '0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      cand  <= sync2;
      for (int k = 0; k < 3; k++) begin
        cnt[k] <= accept[k] ? FILT_SAT : held[k][7:0];
        if (accept[k]) begin
          filt[k]      <= sync2[k];
          qualified[k] <= 1'b1;
        end
      end

      prev_i   <= filt[0];
      i_qual_d <= qualified[0];

      // The first qualified A/B pair only seeds the reference state.
      if (init_done) begin
        prev_ab <= new_ab;
      end else if (qualified[2] && qualified[1]) begin
        prev_ab   <= new_ab;
        init_done <= 1'b1;
      end

      if (preset)                         count_o <= preset_val;
      else if (idx_rise && index_clr_en)  count_o <= '0;
      else if (step_fwd)                  count_o <= count_o + ONE;
      else if (step_rev)                  count_o <= count_o - ONE;

      if (step_fwd)      dir_o <= 1'b1;
      else if (step_rev) dir_o <= 1'b0;

      if (illegal)      err_o <= 1'b1;
      else if (err_clr) err_o <= 1'b0;

      // The accumulator sees every qualified step, even those the counter drops.
      if (win_cnt == WIN_LAST) begin
        win_cnt     <= '0;
        vel_o       <= acc_step;
        acc         <= '0;
        vel_valid_o <= 1'b1;
      end else begin
        win_cnt     <= win_cnt + ONE;
        acc         <= acc_step;
        vel_valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
